// File: rtl/pp_combine.sv
// pp_combine: folds the six 45-bit partial products of a 54x54 unsigned
// multiply into the 108-bit product through two registered stages with
// valid/ready handshaking on both sides and a count of delivered results.
`timescale 1ns/1ps
module pp_combine #(
  parameter int RADIX = 54,
  parameter int PP_W  = 45
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PP_W-1:0]      res_0,
  input  logic [PP_W-1:0]      res_1,
  input  logic [PP_W-1:0]      res_2,
  input  logic [PP_W-1:0]      res_3,
  input  logic [PP_W-1:0]      res_4,
  input  logic [PP_W-1:0]      res_5,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*RADIX-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          done_cnt
);

  // b is split into three 18-bit slices, a into two 27-bit halves.
  localparam int B_W    = RADIX / 3;
  localparam int HALF   = RADIX / 2;
  localparam int SUM_W  = PP_W + 2 * B_W;
  localparam int PROD_W = 2 * RADIX;

  // Weighted sum of one half's three slice products; SUM_W holds it exactly.
  function automatic logic [SUM_W-1:0] comb3(input logic [PP_W-1:0] p0,
                                             input logic [PP_W-1:0] p1,
                                             input logic [PP_W-1:0] p2);
    comb3 = SUM_W'(p0) + (SUM_W'(p1) << B_W) + (SUM_W'(p2) << (2 * B_W));
  endfunction

  // Joins the low-half and high-half sums into the full product.
  function automatic logic [PROD_W-1:0] merge(input logic [SUM_W-1:0] lo,
                                              input logic [SUM_W-1:0] hi);
    merge = PROD_W'(lo) + (PROD_W'(hi) << HALF);
  endfunction

  logic             vld_p1;
  logic             vld_p2;
  logic [SUM_W-1:0] s_lo_p1;
  logic [SUM_W-1:0] s_hi_p1;
  logic             ld_p1;
  logic             ld_p2;

  // A stage may load when it is empty or when its content moves on.
  assign ld_p2     = !vld_p2 || out_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  // Held low during reset so nothing is taken while the pipe is cleared.
  assign in_ready  = rst_n && ld_p1;
  assign out_valid = vld_p2;

  // Stage 1: partial products -> low/high half sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      s_lo_p1 <= '0;
      s_hi_p1 <= '0;
    end else if (ld_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_lo_p1 <= comb3(res_0, res_1, res_2);
        s_hi_p1 <= comb3(res_3, res_4, res_5);
      end
    end
  end

  // Stage 2: half sums -> full product, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      product <= '0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        product <= merge(s_lo_p1, s_hi_p1);
      end
    end
  end

  // Count completed output transfers, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pp_combine.sv
// tb_pp_combine: directed vector table plus hand-written sequences for
// backpressure, counter wrap and mid-flight reset of pp_combine.
`timescale 1ns/1ps
module tb_pp_combine;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [44:0]   res [6];
  logic          in_valid;
  logic          in_ready;
  logic [107:0]  product;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   done_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pp_combine #(.RADIX(54), .PP_W(45)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_0     (res[0]),
    .res_1     (res[1]),
    .res_2     (res[2]),
    .res_3     (res[3]),
    .res_4     (res[4]),
    .res_5     (res[5]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done_cnt  (done_cnt)
  );

  typedef struct packed {
    logic [44:0]  r0;
    logic [44:0]  r1;
    logic [44:0]  r2;
    logic [44:0]  r3;
    logic [44:0]  r4;
    logic [44:0]  r5;
    logic [107:0] exp;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  // (2^27-1)*(2^18-1)
  localparam logic [44:0] M = 45'h1FFFF7FC0001;

  task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Upstream multiplier model: slice a and b and form the six products.
  task automatic set_ab(input logic [53:0] a, input logic [53:0] b);
    res[0] = 45'(a[26:0])  * 45'(b[17:0]);
    res[1] = 45'(a[26:0])  * 45'(b[35:18]);
    res[2] = 45'(a[26:0])  * 45'(b[53:36]);
    res[3] = 45'(a[53:27]) * 45'(b[17:0]);
    res[4] = 45'(a[53:27]) * 45'(b[35:18]);
    res[5] = 45'(a[53:27]) * 45'(b[53:36]);
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(input logic [44:0] r0, input logic [44:0] r1,
                               input logic [44:0] r2, input logic [44:0] r3,
                               input logic [44:0] r4, input logic [44:0] r5,
                               input logic [107:0] exp);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.r4 = r4; v.r5 = r5;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [107:0] q [$];
    logic [107:0] exp_q;
    logic [107:0] cur_exp;
    logic [107:0] prev_prod;
    logic [53:0]  cur_a;
    logic [53:0]  cur_b;
    logic         prev_stall;
    int           sent;
    int           got;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) res[k] = '0;

    // ---------------- reset state ----------------
    #2;
    check("rst_out_valid", 108'(out_valid), 108'd0);
    check("rst_done_cnt",  108'(done_cnt),  108'd0);
    check("rst_product",   product,         108'd0);
    check("rst_in_ready_low", 108'(in_ready), 108'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 108'(in_ready), 108'd1);

    // ---------------- vector table ----------------
    vecs[0] = mkv(45'd15, 0, 0, 0, 0, 0, 108'd15);
    vecs[1] = mkv(1, 0, 0, 0, 0, 0, 108'd1 << 0);
    vecs[2] = mkv(0, 1, 0, 0, 0, 0, 108'd1 << 18);
    vecs[3] = mkv(0, 0, 1, 0, 0, 0, 108'd1 << 36);
    vecs[4] = mkv(0, 0, 0, 1, 0, 0, 108'd1 << 27);
    vecs[5] = mkv(0, 0, 0, 0, 1, 0, 108'd1 << 45);
    vecs[6] = mkv(0, 0, 0, 0, 0, 1, 108'd1 << 63);
    vecs[7] = mkv(M, M, M, M, M, M, 108'hF_FFFF_FFFF_FFFF_8_0000_0000_0000_1);
    vecs[8] = mkv(M, 0, 0, 0, 0, 0, 108'(M));
    vecs[9] = mkv(0, 0, M, 0, 0, M, (108'(M) << 36) + (108'(M) << 63));

    tick();
    for (int i = 0; i < NVEC; i++) begin
      res[0] = vecs[i].r0; res[1] = vecs[i].r1; res[2] = vecs[i].r2;
      res[3] = vecs[i].r3; res[4] = vecs[i].r4; res[5] = vecs[i].r5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), 108'(in_ready), 108'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat_early", i), 108'(out_valid), 108'd0);
      tick();
      check($sformatf("vec%0d_out_valid", i), 108'(out_valid), 108'd1);
      check($sformatf("vec%0d_product", i), product, vecs[i].exp);
      tick();
      check($sformatf("vec%0d_done_cnt", i), 108'(done_cnt), 108'(i + 1));
    end

    // ---------------- stream with 5-cycle stall ----------------
    do_reset();
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_prod = '0;
    cur_a = 54'({$urandom(), $urandom()});
    cur_b = 54'({$urandom(), $urandom()});
    cur_exp = 108'(cur_a) * 108'(cur_b);
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (sent < 10);
      set_ab(cur_a, cur_b);
      @(negedge clk);
      if (cyc == 7) check("stall_in_ready", 108'(in_ready), 108'd0);
      if (prev_stall) begin
        check("stall_hold_valid", 108'(out_valid), 108'd1);
        check("stall_hold_product", product, prev_prod);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected", 108'd1, 108'd0);
        end else begin
          exp_q = q.pop_front();
          check($sformatf("stream_data%0d", got), product, exp_q);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(cur_exp);
        sent++;
        cur_a = 54'({$urandom(), $urandom()});
        cur_b = 54'({$urandom(), $urandom()});
        cur_exp = 108'(cur_a) * 108'(cur_b);
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = product;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 108'(got), 108'd10);
    check("stream_done_cnt", 108'(done_cnt), 108'd10);

    // ---------------- mid-flight reset ----------------
    set_ab(54'd7, 54'd9);
    in_valid = 1'b1;
    tick();
    set_ab(54'd11, 54'd13);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 108'(out_valid), 108'd0);
    check("mrst_product", product, 108'd0);
    check("mrst_done_cnt", 108'(done_cnt), 108'd0);
    check("mrst_in_ready", 108'(in_ready), 108'd0);
    tick();
    check("mrst_hold_valid", 108'(out_valid), 108'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mrst_rel_in_ready", 108'(in_ready), 108'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mrst_no_stale%0d", k), 108'(out_valid), 108'd0);
    end
    set_ab(54'h3F_FFFF_FFFF_FFFF, 54'd2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mrst_next_early", 108'(out_valid), 108'd0);
    tick();
    check("mrst_next_valid", 108'(out_valid), 108'd1);
    check("mrst_next_product", product, 108'h7F_FFFF_FFFF_FFFE);
    tick();
    check("mrst_next_done", 108'(done_cnt), 108'd1);

    // ---------------- done_cnt wrap ----------------
    do_reset();
    set_ab(54'd3, 54'd5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    tick();
    check("wrap_ffff", 108'(done_cnt), 108'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_product", product, 108'd15);
    check("wrap_pre", 108'(done_cnt), 108'hFFFF);
    tick();
    check("wrap_zero", 108'(done_cnt), 108'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
